piso_frame_tx: RTL and testbench

Parametrised parallel-in serial-out UART transmit framer for the Transmitter path. It accepts a DATA_W-bit word over a valid/ready handshake and buffers it. It then serialises one complete asynchronous frame on the line: start bit, data bits, optional parity, and 1 or 2 stop bits. Every bit advances on an external baud-rate enable rather than on every clock.

---
 rtl/piso_frame_tx.sv | 176 +++++++++++++++++
 tb/tb_piso_frame_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_tx.sv
// UART transmit framer: buffers one word, then sends start, data, optional parity and stop bits on baud_tick.
// Optional parity bit is compiled in with `define PISO_FRAME_TX_PARITY_EN.
module piso_frame_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PEND   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("piso_frame_tx: DATA_W must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("piso_frame_tx: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST > 1 || ODD_PARITY > 1) begin : g_bad_flags
        $error("piso_frame_tx: MSB_FIRST and ODD_PARITY must be 0 or 1");
    end

    logic [2:0]        state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d, shifted;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              out_d, ready_d, busy_d, done_d;
    logic              first_bit, next_bit;

`ifdef PISO_FRAME_TX_PARITY_EN
    logic              par, par_d;
`endif

    // Bit order selection: the outgoing bit is always taken from the leading end of the shift register.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted   = {shreg[DATA_W-2:0], 1'b0};
            first_bit = shreg[DATA_W-1];
            next_bit  = shifted[DATA_W-1];
        end else begin
            shifted   = {1'b0, shreg[DATA_W-1:1]};
            first_bit = shreg[0];
            next_bit  = shifted[0];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        out_d   = out;
        ready_d = ready;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef PISO_FRAME_TX_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: begin
                if (load && ready) begin
                    shreg_d = data_in;
`ifdef PISO_FRAME_TX_PARITY_EN
                    par_d   = (^data_in) ^ (ODD_PARITY != 0);
`endif
                    state_d = PEND;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            PEND: begin
                if (baud_tick) begin
                    state_d = START;
                    out_d   = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    out_d   = first_bit;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_d = shifted;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
`ifdef PISO_FRAME_TX_PARITY_EN
                        state_d = PARITY;
                        out_d   = par;
`else
                        state_d = STOP;
                        out_d   = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                        out_d = next_bit;
                    end
                end
            end
`ifdef PISO_FRAME_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (cnt == CNT_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                    out_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                out_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            out   <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef PISO_FRAME_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
            out   <= out_d;
            ready <= ready_d;
            busy  <= busy_d;
            done  <= done_d;
`ifdef PISO_FRAME_TX_PARITY_EN
            par   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: three parameterisations share clk, reset and baud_tick.
module tb_piso_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic [2:0] load;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    wire  [2:0] out_w, ready_w, busy_w, done_w;

    int n_checks = 0;
    int n_fails  = 0;
    int line[$];

    always #5 clk = ~clk;

    piso_frame_tx #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(0), .ODD_PARITY(0)) u0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(d0), .load(load[0]),
        .ready(ready_w[0]), .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    piso_frame_tx #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(1), .ODD_PARITY(1)) u1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(d1), .load(load[1]),
        .ready(ready_w[1]), .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    piso_frame_tx #(.DATA_W(5), .STOP_BITS(2), .MSB_FIRST(0), .ODD_PARITY(0)) u2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(d2), .load(load[2]),
        .ready(ready_w[2]), .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    task automatic tick();
        repeat (15) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic load_word(input int sel, input logic [7:0] word);
        @(negedge clk);
        case (sel)
            0:       d0 = word;
            1:       d1 = word;
            default: d2 = word[4:0];
        endcase
        load[sel] = 1'b1;
        @(negedge clk);
        load[sel] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (out_w !== 3'b111)   begin n_fails++; $display("FAIL reset_out: got %b expected 111", out_w); end
        n_checks++; if (ready_w !== 3'b111) begin n_fails++; $display("FAIL reset_ready: got %b expected 111", ready_w); end
        n_checks++; if (busy_w !== 3'b000)  begin n_fails++; $display("FAIL reset_busy: got %b expected 000", busy_w); end
        n_checks++; if (done_w !== 3'b000)  begin n_fails++; $display("FAIL reset_done: got %b expected 000", done_w); end
    endtask

    task automatic test_basic_frame();
`ifdef PISO_FRAME_TX_PARITY_EN
        line = '{0,1,0,1,0,0,1,0,1,0,1};
`else
        line = '{0,1,0,1,0,0,1,0,1,1};
`endif
        load_word(0, 8'hA5);
        n_checks++; if (ready_w[0] !== 1'b0) begin n_fails++; $display("FAIL basic_ready_low: got %b expected 0", ready_w[0]); end
        n_checks++; if (busy_w[0] !== 1'b1)  begin n_fails++; $display("FAIL basic_busy_high: got %b expected 1", busy_w[0]); end
        n_checks++; if (out_w[0] !== 1'b1)   begin n_fails++; $display("FAIL basic_pend_idle: got %b expected 1", out_w[0]); end
        for (int i = 0; i < line.size(); i++) begin
            tick();
            n_checks++;
            if (out_w[0] !== 1'(line[i])) begin n_fails++; $display("FAIL basic_bit%0d: got %b expected %0d", i, out_w[0], line[i]); end
            n_checks++;
            if (done_w[0] !== 1'b0) begin n_fails++; $display("FAIL basic_early_done%0d: got %b expected 0", i, done_w[0]); end
        end
        tick();
        n_checks++; if (done_w[0] !== 1'b1)  begin n_fails++; $display("FAIL basic_done: got %b expected 1", done_w[0]); end
        n_checks++; if (ready_w[0] !== 1'b1) begin n_fails++; $display("FAIL basic_ready_back: got %b expected 1", ready_w[0]); end
        n_checks++; if (busy_w[0] !== 1'b0)  begin n_fails++; $display("FAIL basic_busy_low: got %b expected 0", busy_w[0]); end
        @(negedge clk);
        n_checks++; if (done_w[0] !== 1'b0)  begin n_fails++; $display("FAIL basic_done_pulse: got %b expected 0", done_w[0]); end
    endtask

    task automatic test_msb_parity();
`ifdef PISO_FRAME_TX_PARITY_EN
        line = '{0,1,0,1,0,0,1,0,1,1,1};
`else
        line = '{0,1,0,1,0,0,1,0,1,1};
`endif
        load_word(1, 8'hA5);
        for (int i = 0; i < line.size(); i++) begin
            tick();
            n_checks++;
            if (out_w[1] !== 1'(line[i])) begin n_fails++; $display("FAIL msb_bit%0d: got %b expected %0d", i, out_w[1], line[i]); end
        end
        tick();
        n_checks++; if (done_w[1] !== 1'b1) begin n_fails++; $display("FAIL msb_done: got %b expected 1", done_w[1]); end
    endtask

    task automatic test_width_stop();
        int busy_end;
`ifdef PISO_FRAME_TX_PARITY_EN
        line = '{0,1,1,0,0,1,1,1,1};
`else
        line = '{0,1,1,0,0,1,1,1};
`endif
        busy_end = -1;
        load_word(2, 8'h13);
        for (int i = 0; i <= line.size(); i++) begin
            tick();
            if (i < line.size()) begin
                n_checks++;
                if (out_w[2] !== 1'(line[i])) begin n_fails++; $display("FAIL w5_bit%0d: got %b expected %0d", i, out_w[2], line[i]); end
            end
            if (busy_end < 0 && busy_w[2] === 1'b0) busy_end = i;
        end
        n_checks++;
        if (busy_end != line.size()) begin n_fails++; $display("FAIL w5_busy_periods: got %0d expected %0d", busy_end, line.size()); end
        n_checks++; if (done_w[2] !== 1'b1) begin n_fails++; $display("FAIL w5_done: got %b expected 1", done_w[2]); end
    endtask

    task automatic test_back_to_back();
        int first[$];
        int second[$];
`ifdef PISO_FRAME_TX_PARITY_EN
        first  = '{0,0,0,0,0,0,0,0,0,0,1};
        second = '{0,1,1,1,1,1,1,1,1,0,1};
`else
        first  = '{0,0,0,0,0,0,0,0,0,1};
        second = '{0,1,1,1,1,1,1,1,1,1};
`endif
        load_word(0, 8'h00);
        for (int i = 0; i < first.size(); i++) begin
            tick();
            if (i == 3) begin
                d0      = 8'hFF;
                load[0] = 1'b1;
            end
            n_checks++;
            if (out_w[0] !== 1'(first[i])) begin n_fails++; $display("FAIL b2b_first_bit%0d: got %b expected %0d", i, out_w[0], first[i]); end
        end
        tick();
        n_checks++; if (done_w[0] !== 1'b1)  begin n_fails++; $display("FAIL b2b_done1: got %b expected 1", done_w[0]); end
        n_checks++; if (ready_w[0] !== 1'b1) begin n_fails++; $display("FAIL b2b_ready1: got %b expected 1", ready_w[0]); end
        @(negedge clk);
        load[0] = 1'b0;
        n_checks++; if (ready_w[0] !== 1'b0) begin n_fails++; $display("FAIL b2b_accept2: got %b expected 0", ready_w[0]); end
        n_checks++; if (busy_w[0] !== 1'b1)  begin n_fails++; $display("FAIL b2b_busy2: got %b expected 1", busy_w[0]); end
        for (int i = 0; i < second.size(); i++) begin
            tick();
            n_checks++;
            if (out_w[0] !== 1'(second[i])) begin n_fails++; $display("FAIL b2b_second_bit%0d: got %b expected %0d", i, out_w[0], second[i]); end
        end
        tick();
        n_checks++; if (done_w[0] !== 1'b1) begin n_fails++; $display("FAIL b2b_done2: got %b expected 1", done_w[0]); end
    endtask

    task automatic test_reset_mid_frame();
`ifdef PISO_FRAME_TX_PARITY_EN
        line = '{0,1,0,0,0,0,0,0,1,0,1};
`else
        line = '{0,1,0,0,0,0,0,0,1,1};
`endif
        load_word(0, 8'h3C);
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (out_w[0] !== 1'b1) begin n_fails++; $display("FAIL rst_pre_bit3: got %b expected 1", out_w[0]); end
        reset     = 1'b1;
        baud_tick = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        baud_tick = 1'b0;
        n_checks++; if (out_w[0] !== 1'b1)   begin n_fails++; $display("FAIL rst_mid_out: got %b expected 1", out_w[0]); end
        n_checks++; if (ready_w[0] !== 1'b1) begin n_fails++; $display("FAIL rst_mid_ready: got %b expected 1", ready_w[0]); end
        n_checks++; if (busy_w[0] !== 1'b0)  begin n_fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy_w[0]); end
        n_checks++; if (done_w[0] !== 1'b0)  begin n_fails++; $display("FAIL rst_mid_done: got %b expected 0", done_w[0]); end
        tick();
        n_checks++; if (out_w[0] !== 1'b1) begin n_fails++; $display("FAIL rst_no_resume: got %b expected 1", out_w[0]); end
        load_word(0, 8'h81);
        for (int i = 0; i < line.size(); i++) begin
            tick();
            n_checks++;
            if (out_w[0] !== 1'(line[i])) begin n_fails++; $display("FAIL rst_new_bit%0d: got %b expected %0d", i, out_w[0], line[i]); end
        end
        tick();
        n_checks++; if (done_w[0] !== 1'b1) begin n_fails++; $display("FAIL rst_new_done: got %b expected 1", done_w[0]); end
    endtask

    task automatic test_tick_in_accept();
`ifdef PISO_FRAME_TX_PARITY_EN
        line = '{0,0,1,0,1,1,0,1,0,0,1};
`else
        line = '{0,0,1,0,1,1,0,1,0,1};
`endif
        @(negedge clk);
        d0        = 8'h5A;
        load[0]   = 1'b1;
        baud_tick = 1'b1;
        @(negedge clk);
        load[0]   = 1'b0;
        baud_tick = 1'b0;
        n_checks++; if (ready_w[0] !== 1'b0) begin n_fails++; $display("FAIL tacc_accept: got %b expected 0", ready_w[0]); end
        repeat (3) @(negedge clk);
        n_checks++; if (out_w[0] !== 1'b1) begin n_fails++; $display("FAIL tacc_no_start: got %b expected 1", out_w[0]); end
        for (int i = 0; i < line.size(); i++) begin
            tick();
            n_checks++;
            if (out_w[0] !== 1'(line[i])) begin n_fails++; $display("FAIL tacc_bit%0d: got %b expected %0d", i, out_w[0], line[i]); end
        end
        tick();
        n_checks++; if (done_w[0] !== 1'b1) begin n_fails++; $display("FAIL tacc_done: got %b expected 1", done_w[0]); end
    endtask

    initial begin
        reset     = 1'b1;
        baud_tick = 1'b0;
        load      = 3'b000;
        d0        = 8'h00;
        d1        = 8'h00;
        d2        = 5'h00;
        test_reset();
        test_basic_frame();
        test_msb_parity();
        test_width_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_in_accept();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
